// File: rtl/gr5_mem_arbiter.sv
// gr5_mem_arbiter: shares the single Grande Risco 5 main-memory port between
// the I-cache refill path and the D-cache refill/write-back path.
// One transaction is in flight at a time, and every output comes straight from a flop.
// Compile-time option GR5_ARB_ROUND_ROBIN_EN: when defined, a tie goes to the
// port that was not granted last. When undefined, the D-cache always wins a tie.
module gr5_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_ack,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_ack,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack,
    output logic                    busy,
    output logic                    grant_d
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DATA_WIDTH-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
    logic                    i_ack_q, i_ack_d;
    logic                    d_ack_q, d_ack_d;
    logic                    busy_q, busy_d;
    logic                    grant_d_q, grant_d_d;
    logic                    pick_d;

`ifdef GR5_ARB_ROUND_ROBIN_EN
    // Points at the port that should win the next tie; reset favours the I-cache.
    logic                    rr_prefer_d_q, rr_prefer_d_d;
`endif

    // Arbitration decision for a grant issued from IDLE.
    always_comb begin
        pick_d = d_req;
`ifdef GR5_ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            pick_d = rr_prefer_d_q;
        end
`endif
    end

    // Next-state and next-output logic; everything holds unless a transition changes it.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        grant_d_d   = grant_d_q;
`ifdef GR5_ARB_ROUND_ROBIN_EN
        rr_prefer_d_d = rr_prefer_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    mem_req_d = 1'b1;
                    grant_d_d = pick_d;
`ifdef GR5_ARB_ROUND_ROBIN_EN
                    rr_prefer_d_d = ~pick_d;
`endif
                    if (pick_d) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_wstrb_d = d_wstrb;
                        state_d     = GRANT_D;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                        state_d     = GRANT_I;
                    end
                end
            end
            GRANT_I: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    i_rdata_d = mem_rdata;
                    i_ack_d   = 1'b1;
                    state_d   = DONE;
                end
            end
            GRANT_D: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    d_rdata_d = mem_rdata;
                    d_ack_d   = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
            grant_d_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            busy_q      <= busy_d;
            grant_d_q   <= grant_d_d;
        end
    end

`ifdef GR5_ARB_ROUND_ROBIN_EN
    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_prefer_d_q <= 1'b0;
        end else begin
            rr_prefer_d_q <= rr_prefer_d_d;
        end
    end
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign busy      = busy_q;
    assign grant_d   = grant_d_q;

endmodule

// File: tb/tb_gr5_mem_arbiter.sv
// tb_gr5_mem_arbiter: bench for gr5_mem_arbiter.
// Requesters, a memory slave model and a per-port scoreboard all advance together
// once per falling edge inside tick(). Expected contention order follows
// GR5_ARB_ROUND_ROBIN_EN.
module tb_gr5_mem_arbiter;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          wait_cyc;
        logic [31:0] rdata;
        int          lat;
        int          issue;
    } txn_t;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        grant_d;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    txn_t i_pend[$];
    txn_t d_pend[$];
    txn_t i_sb[$];
    txn_t d_sb[$];
    logic gq[$];

    logic        prev_i_ack, prev_d_ack;
    logic [31:0] exp_i_rdata, exp_d_rdata;
    int          i_ack_cnt, d_ack_cnt;

    logic        mem_active, stray_pending, check_gap, have_last;
    int          mem_cnt, cur_wait, last_grant_cyc;
    logic [31:0] cur_data;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;

    txn_t vec[6];

    gr5_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .busy(busy), .grant_d(grant_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mkTxn(input logic is_d, input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] wstrb,
                                   input int wait_cyc, input logic [31:0] rdata, input int lat);
        txn_t t;
        t.is_d     = is_d;
        t.we       = is_d ? we : 1'b0;
        t.addr     = addr;
        t.wdata    = wdata;
        t.wstrb    = is_d ? wstrb : 4'b0000;
        t.wait_cyc = wait_cyc;
        t.rdata    = rdata;
        t.lat      = lat;
        t.issue    = 0;
        return t;
    endfunction

    task automatic applyStimulus(input txn_t t);
        if (t.is_d) d_pend.push_back(t);
        else        i_pend.push_back(t);
        gq.push_back(t.is_d);
    endtask

    task automatic flushBench();
        i_pend.delete(); d_pend.delete(); i_sb.delete(); d_sb.delete(); gq.delete();
        i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        mem_active = 1'b0; stray_pending = 1'b0; have_last = 1'b0; check_gap = 1'b0;
        prev_i_ack = 1'b0; prev_d_ack = 1'b0;
        exp_i_rdata = 32'h0; exp_d_rdata = 32'h0;
    endtask

    task automatic tick();
        txn_t e;
        logic exp_d;
        @(negedge clk);
        if (i_ack) begin
            i_ack_cnt++;
            checkOutput("i_ack_width", 32'(prev_i_ack), 32'd0);
            if (i_sb.size() == 0) begin
                checkOutput("i_ack_unexpected", 32'(i_ack), 32'd0);
            end else begin
                e = i_sb.pop_front();
                checkOutput("i_rdata", i_rdata, e.rdata);
                if (e.lat != 0) checkOutput("i_latency", 32'(cyc - e.issue), 32'(e.lat));
                exp_i_rdata = e.rdata;
            end
        end
        if (d_ack) begin
            d_ack_cnt++;
            checkOutput("d_ack_width", 32'(prev_d_ack), 32'd0);
            if (d_sb.size() == 0) begin
                checkOutput("d_ack_unexpected", 32'(d_ack), 32'd0);
            end else begin
                e = d_sb.pop_front();
                checkOutput("d_rdata", d_rdata, e.rdata);
                if (e.lat != 0) checkOutput("d_latency", 32'(cyc - e.issue), 32'(e.lat));
                exp_d_rdata = e.rdata;
            end
        end
        prev_i_ack = i_ack;
        prev_d_ack = d_ack;

        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (stray_pending) begin
            mem_ack = 1'b1;
            mem_rdata = 32'hBAD0BAD0;
            stray_pending = 1'b0;
        end else if (mem_req) begin
            if (!mem_active) begin
                mem_active = 1'b1;
                mem_cnt = 0;
                cur_wait = 0;
                cur_data = 32'h0;
                if (gq.size() == 0) begin
                    checkOutput("grant_expected", 32'(mem_req), 32'd0);
                end else begin
                    exp_d = gq.pop_front();
                    checkOutput("grant_d", 32'(grant_d), 32'(exp_d));
                    if ((exp_d && d_sb.size() == 0) || (!exp_d && i_sb.size() == 0)) begin
                        checkOutput("grant_owner", 32'(mem_req), 32'd0);
                    end else begin
                        if (exp_d) e = d_sb[0];
                        else       e = i_sb[0];
                        checkOutput("mem_we", 32'(mem_we), 32'(e.we));
                        checkOutput("mem_addr", mem_addr, e.addr);
                        checkOutput("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
                        if (exp_d) checkOutput("mem_wdata", mem_wdata, e.wdata);
                        cur_wait = e.wait_cyc;
                        cur_data = e.rdata;
                    end
                end
                if (check_gap && have_last) checkOutput("grant_spacing", 32'(cyc - last_grant_cyc), 32'd3);
                last_grant_cyc = cyc;
                have_last = 1'b1;
                cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata; cap_wstrb = mem_wstrb;
            end else begin
                checkOutput("mem_we_stable", 32'(mem_we), 32'(cap_we));
                checkOutput("mem_addr_stable", mem_addr, cap_addr);
                checkOutput("mem_wdata_stable", mem_wdata, cap_wdata);
                checkOutput("mem_wstrb_stable", 32'(mem_wstrb), 32'(cap_wstrb));
            end
            if (mem_cnt == cur_wait) begin
                mem_ack = 1'b1;
                mem_rdata = cur_data;
                mem_active = 1'b0;
            end else begin
                mem_cnt++;
            end
        end

        if (i_req && i_ack) i_req = 1'b0;
        if (!i_req && i_pend.size() > 0) begin
            e = i_pend.pop_front();
            e.issue = cyc;
            i_req = 1'b1;
            i_addr = e.addr;
            i_sb.push_back(e);
        end
        if (d_req && d_ack) d_req = 1'b0;
        if (!d_req && d_pend.size() > 0) begin
            e = d_pend.pop_front();
            e.issue = cyc;
            d_req = 1'b1;
            d_we = e.we;
            d_addr = e.addr;
            d_wdata = e.wdata;
            d_wstrb = e.wstrb;
            d_sb.push_back(e);
        end
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (n < 200 && (i_pend.size() != 0 || d_pend.size() != 0 || i_sb.size() != 0 ||
               d_sb.size() != 0 || i_req || d_req || busy || mem_ack)) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checkOutput({name, "_timeout"}, 32'(n), 32'd0);
            flushBench();
        end
        tick();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        checkOutput({tag, "_i_ack"}, 32'(i_ack), 32'd0);
        checkOutput({tag, "_d_ack"}, 32'(d_ack), 32'd0);
        checkOutput({tag, "_i_rdata"}, i_rdata, 32'd0);
        checkOutput({tag, "_d_rdata"}, d_rdata, 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_grant_d"}, 32'(grant_d), 32'd0);
    endtask

    task automatic runVector(input txn_t t, input string name);
        int ic, dc;
        ic = i_ack_cnt;
        dc = d_ack_cnt;
        applyStimulus(t);
        waitIdle(name);
        checkOutput({name, "_i_ack_count"}, 32'(i_ack_cnt - ic), t.is_d ? 32'd0 : 32'd1);
        checkOutput({name, "_d_ack_count"}, 32'(d_ack_cnt - dc), t.is_d ? 32'd1 : 32'd0);
        checkOutput({name, "_i_rdata_hold"}, i_rdata, exp_i_rdata);
        checkOutput({name, "_d_rdata_hold"}, d_rdata, exp_d_rdata);
    endtask

    initial begin
        int ic, dc, n;
        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        i_ack_cnt = 0; d_ack_cnt = 0;
        mem_cnt = 0; cur_wait = 0; cur_data = 32'h0; last_grant_cyc = 0;
        cap_we = 1'b0; cap_addr = 32'h0; cap_wdata = 32'h0; cap_wstrb = 4'h0;
        flushBench();

        vec[0] = mkTxn(1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'b0000, 0, 32'hDEADBEEF, 2);
        vec[1] = mkTxn(1'b1, 1'b1, 32'h0000_2004, 32'h12345678, 4'b0011, 5, 32'hCAFE0001, 7);
        vec[2] = mkTxn(1'b1, 1'b0, 32'h0000_3000, 32'hA5A5A5A5, 4'b0000, 1, 32'h0BADF00D, 3);
        vec[3] = mkTxn(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 2, 32'h80000001, 4);
        vec[4] = mkTxn(1'b1, 1'b1, 32'h0000_0000, 32'hFFFFFFFF, 4'b1111, 0, 32'h00C0FFEE, 2);
        vec[5] = mkTxn(1'b0, 1'b0, 32'h0000_0044, 32'h0,         4'b0000, 3, 32'h13579BDF, 5);

        repeat (3) @(negedge clk);
        checkResetValues("por");
        rst = 1'b0;
        tick();

        $display("[TB] table-driven single transactions");
        for (int i = 0; i < 6; i++) begin
            runVector(vec[i], $sformatf("vec%0d", i));
        end

        $display("[TB] stray mem_ack while idle");
        ic = i_ack_cnt;
        dc = d_ack_cnt;
        stray_pending = 1'b1;
        repeat (4) tick();
        checkOutput("stray_i_ack_count", 32'(i_ack_cnt - ic), 32'd0);
        checkOutput("stray_d_ack_count", 32'(d_ack_cnt - dc), 32'd0);
        checkOutput("stray_i_rdata", i_rdata, exp_i_rdata);
        checkOutput("stray_d_rdata", d_rdata, exp_d_rdata);
        checkOutput("stray_busy", 32'(busy), 32'd0);
        runVector(mkTxn(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'b0000, 0, 32'h2468ACE0, 2), "post_stray");

        $display("[TB] reset from idle");
        rst = 1'b1;
        #1;
        checkResetValues("idle_rst");
        flushBench();
        tick(); tick();
        rst = 1'b0;
        tick();

        $display("[TB] contention");
        check_gap = 1'b1;
        have_last = 1'b0;
`ifdef GR5_ARB_ROUND_ROBIN_EN
        i_pend.push_back(mkTxn(1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'b0000, 0, 32'h11110000, 0));
        i_pend.push_back(mkTxn(1'b0, 1'b0, 32'h0000_1004, 32'h0, 4'b0000, 0, 32'h11110004, 0));
        d_pend.push_back(mkTxn(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'b0000, 0, 32'h22220000, 0));
        d_pend.push_back(mkTxn(1'b1, 1'b1, 32'h0000_5004, 32'h77, 4'b0001, 0, 32'h22220004, 0));
        gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0); gq.push_back(1'b1);
`else
        i_pend.push_back(mkTxn(1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'b0000, 0, 32'h11110000, 0));
        i_pend.push_back(mkTxn(1'b0, 1'b0, 32'h0000_1004, 32'h0, 4'b0000, 0, 32'h11110004, 0));
        d_pend.push_back(mkTxn(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'b0000, 0, 32'h22220000, 0));
        d_pend.push_back(mkTxn(1'b1, 1'b1, 32'h0000_5004, 32'h77, 4'b0001, 0, 32'h22220004, 0));
        d_pend.push_back(mkTxn(1'b1, 1'b0, 32'h0000_5008, 32'h0, 4'b0000, 0, 32'h22220008, 0));
        gq.push_back(1'b1); gq.push_back(1'b1); gq.push_back(1'b1);
        gq.push_back(1'b0); gq.push_back(1'b0);
`endif
        ic = i_ack_cnt;
        dc = d_ack_cnt;
        waitIdle("contention");
        check_gap = 1'b0;
`ifdef GR5_ARB_ROUND_ROBIN_EN
        checkOutput("contention_i_acks", 32'(i_ack_cnt - ic), 32'd2);
        checkOutput("contention_d_acks", 32'(d_ack_cnt - dc), 32'd2);
        checkOutput("contention_last_grant", 32'(grant_d), 32'd1);
`else
        checkOutput("contention_i_acks", 32'(i_ack_cnt - ic), 32'd2);
        checkOutput("contention_d_acks", 32'(d_ack_cnt - dc), 32'd3);
        checkOutput("contention_last_grant", 32'(grant_d), 32'd0);
`endif

        $display("[TB] reset during a D-cache grant");
        applyStimulus(mkTxn(1'b1, 1'b1, 32'h0000_ABC0, 32'h55AA55AA, 4'b1100, 40, 32'h0, 0));
        n = 0;
        while (!mem_active && n < 20) begin
            tick();
            n++;
        end
        checkOutput("rst_mid_reached_grant", 32'(mem_active), 32'd1);
        tick(); tick();
        checkOutput("rst_mid_pre_grant_d", 32'(grant_d), 32'd1);
        checkOutput("rst_mid_pre_mem_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        checkResetValues("mid_rst");
        flushBench();
        tick(); tick();
        rst = 1'b0;
        tick();
        runVector(mkTxn(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'b0000, 0, 32'h0F0F0F0F, 2), "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
